// File: rtl/switch_out_port.sv
// switch_out_port: per-output-port packet FIFO that advertises ready only when
// a complete packet is stored and serialises one packet per read request.
//
// Ports:
//   clock, reset_n           clock, asynchronous active-low reset
//   in_data/in_valid/in_eop  fabric byte stream, eop marks last byte of a packet
//   in_ready                 buffer accepts a byte this cycle
//   port                     egress byte, 8'h00 when not sending
//   read                     consumer request for one packet
//   ready                    a complete packet is buffered and the block is idle
//   pkt_count                number of complete packets buffered
//   drop_count               dropped packets (only with SW_OUT_PORT_DROP_EN)
//
// Build option SW_OUT_PORT_DROP_EN: in_ready is tied high and a packet that
// overflows the buffer is discarded through its eop instead of backpressured.
module switch_out_port #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_eop,
    output logic          in_ready,
    output logic [7:0]    port,
    input  logic          read,
    output logic          ready,
`ifdef SW_OUT_PORT_DROP_EN
    output logic [15:0]   drop_count,
`endif
    output logic [AW:0]   pkt_count
);
    typedef enum logic {IDLE, SEND} state_t;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t        state, state_next;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, wr_ptr_next, rd_ptr;
    logic [AW:0]   level, level_next, pkt_next;
    logic [7:0]    port_next;
    logic          last, full, wr_en, commit, start, rd_en, done, ready_next;

    assign full   = level == FULL;
    assign commit = wr_en && in_eop;
    assign start  = state == IDLE && read && ready;
    assign done   = state == SEND && last;
    // in SEND a byte is loaded every edge until the eop byte has been loaded
    assign rd_en  = start || (state == SEND && !last);

`ifdef SW_OUT_PORT_DROP_EN
    logic          dropping, discard, rewind;
    logic [AW-1:0] sop_ptr;
    logic [AW:0]   pend;

    assign in_ready    = reset_n;
    // once a packet overflows, the rest of it is discarded even if space frees up
    assign discard     = in_valid && (dropping || full);
    assign rewind      = discard && in_eop;
    assign wr_en       = in_valid && !discard;
    assign wr_ptr_next = rewind ? sop_ptr : wr_ptr + AW'(wr_en);
    assign level_next  = level + (AW+1)'(wr_en) - (AW+1)'(rd_en) - (rewind ? pend : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dropping   <= 1'b0;
            sop_ptr    <= '0;
            pend       <= '0;
            drop_count <= '0;
        end else begin
            dropping <= (dropping || discard) && !rewind;
            pend     <= (commit || rewind) ? '0 : pend + (AW+1)'(wr_en);
            if (commit)
                sop_ptr <= wr_ptr + 1'b1;
            if (rewind && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign in_ready    = reset_n && !full;
    assign wr_en       = in_valid && !full;
    assign wr_ptr_next = wr_ptr + AW'(wr_en);
    assign level_next  = level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
`endif

    always_comb begin
        state_next = state;
        if (start)
            state_next = SEND;
        else if (done)
            state_next = IDLE;
        pkt_next   = pkt_count + (AW+1)'(commit) - (AW+1)'(done);
        // ready is registered from next-state values so it rises the edge a packet completes
        ready_next = state_next == IDLE && pkt_next != '0;
        port_next  = rd_en ? mem[rd_ptr][7:0] : 8'h00;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_count <= '0;
            port      <= 8'h00;
            ready     <= 1'b0;
            last      <= 1'b0;
        end else begin
            state     <= state_next;
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr + AW'(rd_en);
            level     <= level_next;
            pkt_count <= pkt_next;
            port      <= port_next;
            ready     <= ready_next;
            last      <= rd_en && mem[rd_ptr][8];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= {in_eop, in_data};
    end
endmodule

// File: tb/tb_switch_out_port.sv
// tb_switch_out_port: randomized scoreboard bench for switch_out_port.
module tb_switch_out_port;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_eop = 1'b0;
    logic        read = 1'b0;
    logic        in_ready, ready;
    logic [7:0]  port;
    logic [AW:0] pkt_count;
`ifdef SW_OUT_PORT_DROP_EN
    logic [15:0] drop_count;
    localparam int MAXLEN = DEPTH + 2;
    bit          dropping = 1'b0;
    int          drops = 0;
`else
    localparam int MAXLEN = DEPTH;
`endif

    switch_out_port #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_eop(in_eop), .in_ready(in_ready), .port(port), .read(read), .ready(ready),
`ifdef SW_OUT_PORT_DROP_EN
        .drop_count(drop_count),
`endif
        .pkt_count(pkt_count)
    );

    initial forever #5 clock = ~clock;

    int         checks = 0, errors = 0;
    int         level_m = 0, left = 0;
    int         len_q[$];
    logic [7:0] exp_data[$];
    logic [7:0] pend[$];
    bit         busy = 1'b0, ready_m = 1'b0, out_byte = 1'b0, rd_rand = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: bytes of completed packets queue up in arrival order;
    // a granted read streams one packet, then idles for one cycle
    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            level_m = 0; left = 0; busy = 0; ready_m = 0; out_byte = 0;
            len_q.delete(); exp_data.delete(); pend.delete();
`ifdef SW_OUT_PORT_DROP_EN
            dropping = 0; drops = 0;
`endif
        end else begin
            int  lvl0;
            bit  ld, wr;
            lvl0 = level_m;
            ld = 0;
            if (!busy && read && ready_m) begin
                busy = 1; left = len_q[0] - 1; ld = 1;
            end else if (busy && left > 0) begin
                left--; ld = 1;
            end else if (busy) begin
                busy = 0; void'(len_q.pop_front());
            end
            if (ld) level_m--;
            wr = 0;
`ifdef SW_OUT_PORT_DROP_EN
            if (in_valid) begin
                if (dropping || lvl0 == DEPTH) begin
                    dropping = 1;
                    if (in_eop) begin
                        level_m -= pend.size();
                        pend.delete();
                        dropping = 0;
                        if (drops != 65535) drops++;
                    end
                end else wr = 1;
            end
`else
            wr = in_valid && lvl0 != DEPTH;
`endif
            if (wr) begin
                level_m++;
                pend.push_back(in_data);
                if (in_eop) begin
                    len_q.push_back(pend.size());
                    foreach (pend[i]) exp_data.push_back(pend[i]);
                    pend.delete();
                end
            end
            ready_m = !busy && len_q.size() > 0;
            out_byte = ld;
        end
    end

    // monitor: compare DUT outputs mid-cycle, popping the byte scoreboard on every loaded byte
    initial forever begin
        @(negedge clock);
        if (!reset_n) begin
            check("rst_port", port, 0);
            check("rst_ready", ready, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_pkt_count", pkt_count, 0);
        end else begin
            check("ready", ready, ready_m);
            check("pkt_count", pkt_count, len_q.size());
`ifdef SW_OUT_PORT_DROP_EN
            check("in_ready", in_ready, 1);
            check("drop_count", drop_count, drops);
`else
            check("in_ready", in_ready, level_m != DEPTH);
`endif
            if (out_byte) begin
                if (exp_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL port_underflow actual=%0h expected=none t=%0t", port, $time);
                end else check("port_byte", port, exp_data.pop_front());
            end else check("port_idle", port, 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic put(input logic [7:0] d, input logic e);
        int n = 0;
        @(negedge clock);
        in_valid = 1; in_data = d; in_eop = e;
        #1;
        while (!in_ready) begin
            if (++n > 500) begin
                checks++; errors++;
                $display("FAIL put_timeout actual=in_ready_low expected=accept t=%0t", $time);
                break;
            end
            @(negedge clock); #1;
        end
        @(posedge clock);
        #1 in_valid = 0;
    endtask

    task automatic pkt(input int len);
        for (int i = 0; i < len; i++) begin
            put(8'($urandom), i == len - 1);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    task automatic pulse_read();
        @(negedge clock); read = 1;
        @(negedge clock); read = 0;
    endtask

    task automatic drain(input int n);
        @(negedge clock); read = 1;
        idle(n);
        read = 0;
    endtask

    initial forever begin
        @(negedge clock);
        if (rd_rand) read = $urandom_range(0, 2) == 0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        idle(3);
        #2 reset_n = 1;
        put(8'hA1, 0); put(8'hB2, 0); put(8'hC3, 1);
        idle(2); pulse_read(); idle(6);
        put(8'h11, 0); put(8'h22, 0); idle(3); put(8'h33, 1);
        idle(2); pulse_read(); idle(6);
        put(8'h51, 0); put(8'h52, 1); put(8'h61, 0); put(8'h62, 1);
        idle(1); drain(12);
        fork
            for (int i = 0; i < 6; i++) put(8'h40 + 8'(i), i == 3 || i == 5);
            begin idle(8); pulse_read(); end
        join
        idle(2); pulse_read(); idle(8);
        drain(12);
`ifdef SW_OUT_PORT_DROP_EN
        for (int i = 0; i < 6; i++) put(8'h70 + 8'(i), i == 5);
        put(8'h81, 0); put(8'h82, 1);
        idle(1); pulse_read(); idle(6);
`endif
        put(8'hD1, 0); put(8'hE2, 0); put(8'hF3, 1);
        idle(1);
        @(negedge clock); read = 1;
        @(posedge clock);
        @(negedge clock); read = 0;
        @(posedge clock);
        #2 reset_n = 0;
        #1;
        check("async_rst_port", port, 0);
        check("async_rst_ready", ready, 0);
        check("async_rst_pkt_count", pkt_count, 0);
        check("async_rst_in_ready", in_ready, 0);
        @(negedge clock); #2 reset_n = 1;
        put(8'h0F, 0); put(8'h00, 0); put(8'hF0, 1);
        idle(1); pulse_read(); idle(6);
        rd_rand = 1;
        repeat (60) begin
            pkt($urandom_range(1, MAXLEN));
            idle($urandom_range(0, 2));
        end
        @(negedge clock); rd_rand = 0; read = 1;
        idle(40);
        read = 0;
        idle(2);
        check("drained", exp_data.size() + len_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
